fwft_sync_fifo: RTL and testbench



---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ram.sv | 30 +++
 rtl/fwft_sync_fifo.sv | 115 +++++++++++
 tb/tb_fwft_sync_fifo.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family (sync and async variants).
//   clog2       : ceiling log2 of a positive integer
//   ptr_width   : pointer width for a given depth (address bits + wrap bit)
//   FIFO_MODE_* : read-mode selector values for the FWFT parameter
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One extra bit beyond the address so full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DWIDTH register array: synchronous write, asynchronous read.
// The array is deliberately not reset.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module fifo_ram #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fwft_sync_fifo.sv
// Single-clock FIFO with selectable first-word-fall-through or standard read mode.
//   clk, rst      : clock, asynchronous active-high reset
//   flush         : synchronous clear of contents (wins over read/write)
//   din, write    : write data and request; full/almost_full report space
//   overflow      : one-cycle pulse after a write refused because the FIFO was full
//   read          : pop request
//   dout/dout_vld : FWFT=1 head word, valid == !empty; FWFT=0 registered word,
//                   valid for one cycle after each accepted pop
//   empty/almost_empty, count : occupancy
//   underflow     : one-cycle pulse after a read refused because the FIFO was empty
//
// Handshake: write is a request qualified by !full (or a same-cycle accepted pop);
// read is a request qualified by !empty. A refused request is dropped, not held,
// and is reported on overflow/underflow the cycle after the edge it was seen at.
module fwft_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int DEPTH       = 16,
  parameter int AMOST_FULL  = 4,
  parameter int AMOST_EMPTY = 4,
  parameter int FWFT        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [DWIDTH-1:0]       din,
  input  logic                    write,
  output logic                    full,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    read,
  output logic [DWIDTH-1:0]       dout,
  output logic                    dout_vld,
  output logic                    empty,
  output logic                    almost_empty,
  output logic                    underflow,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] AF_LVL = PW'(DEPTH - AMOST_FULL);
  localparam logic [PW-1:0] AE_LVL = PW'(AMOST_EMPTY);

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              wr_en, rd_en;
  logic              overflow_q, underflow_q;
  logic [DWIDTH-1:0] rd_data;

  // Flags decode from registered pointers only.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // A pop in the same cycle frees the slot a full FIFO needs for the write.
  assign rd_en = read & ~empty & ~flush;
  assign wr_en = write & (~full | rd_en) & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= write & full & ~rd_en & ~flush;
      underflow_q <= read & empty & ~flush;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign dout     = rd_data;
      assign dout_vld = ~empty;
    end else begin : g_std
      logic [DWIDTH-1:0] dout_q;
      logic              vld_q;
      // rd_en is already low during flush, so flush also clears vld_q.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_en;
          if (rd_en) dout_q <= rd_data;
        end
      end
      assign dout     = dout_q;
      assign dout_vld = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_fwft_sync_fifo.sv
module tb_fwft_sync_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic [DW-1:0] din = '0;
  logic          write = 1'b0;
  logic          read = 1'b0;

  // _f : FWFT=1 instance, _s : FWFT=0 instance; both see the same stimulus
  logic          full_f, af_f, ovf_f, vld_f, empty_f, ae_f, unf_f;
  logic [DW-1:0] dout_f;
  logic [4:0]    count_f;
  logic          full_s, af_s, ovf_s, vld_s, empty_s, ae_s, unf_s;
  logic [DW-1:0] dout_s;
  logic [4:0]    count_s;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];

  fwft_sync_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AMOST_FULL(4), .AMOST_EMPTY(4), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .write(write),
    .full(full_f), .almost_full(af_f), .overflow(ovf_f), .read(read),
    .dout(dout_f), .dout_vld(vld_f), .empty(empty_f), .almost_empty(ae_f),
    .underflow(unf_f), .count(count_f)
  );

  fwft_sync_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AMOST_FULL(4), .AMOST_EMPTY(4), .FWFT(0)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .din(din), .write(write),
    .full(full_s), .almost_full(af_s), .overflow(ovf_s), .read(read),
    .dout(dout_s), .dout_vld(vld_s), .empty(empty_s), .almost_empty(ae_s),
    .underflow(unf_s), .count(count_s)
  );

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 1'b0; read = 1'b0; flush = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      write = 1'b1; din = base + DW'(i);
      step();
    end
    idle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; idle();
    step(); step();
    rst = 1'b0;
    step(); step();
    // order: empty, almost_empty, full, almost_full, overflow, underflow, dout_vld
    checks++;
    if ({empty_f, ae_f, full_f, af_f, ovf_f, unf_f, vld_f} !== 7'b1100000) begin
      errors++; $display("FAIL reset_flags_f got=%b want=1100000", {empty_f, ae_f, full_f, af_f, ovf_f, unf_f, vld_f});
    end
    checks++;
    if ({empty_s, ae_s, full_s, af_s, ovf_s, unf_s, vld_s} !== 7'b1100000) begin
      errors++; $display("FAIL reset_flags_s got=%b want=1100000", {empty_s, ae_s, full_s, af_s, ovf_s, unf_s, vld_s});
    end
    checks++;
    if (count_f !== 5'd0 || count_s !== 5'd0) begin
      errors++; $display("FAIL reset_count got=%0d/%0d want=0", count_f, count_s);
    end
    checks++;
    if (dout_s !== 32'h0) begin
      errors++; $display("FAIL reset_dout_s got=%h want=0", dout_s);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      write = 1'b1; din = DW'(i);
      step();
      checks++;
      if (count_f !== 5'(i + 1) || count_s !== 5'(i + 1)) begin
        errors++; $display("FAIL fill_count i=%0d got=%0d/%0d want=%0d", i, count_f, count_s, i + 1);
      end
      checks++;
      if (af_f !== (i + 1 >= 12) || af_s !== (i + 1 >= 12)) begin
        errors++; $display("FAIL fill_almost_full i=%0d got=%b/%b want=%b", i, af_f, af_s, (i + 1 >= 12));
      end
      checks++;
      if (full_f !== (i + 1 == DEPTH) || ae_f !== (i + 1 <= 4)) begin
        errors++; $display("FAIL fill_full_ae i=%0d got=%b%b want=%b%b", i, full_f, ae_f, (i + 1 == DEPTH), (i + 1 <= 4));
      end
    end
    // 17th write is refused
    write = 1'b1; din = 32'hDEAD;
    step();
    idle();
    checks++;
    if (ovf_f !== 1'b1 || ovf_s !== 1'b1 || count_f !== 5'd16) begin
      errors++; $display("FAIL overflow_pulse got=%b%b cnt=%0d want=11 cnt=16", ovf_f, ovf_s, count_f);
    end
    step();
    checks++;
    if (ovf_f !== 1'b0 || ovf_s !== 1'b0 || count_s !== 5'd16) begin
      errors++; $display("FAIL overflow_clear got=%b%b cnt=%0d want=00 cnt=16", ovf_f, ovf_s, count_s);
    end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (dout_f !== DW'(k) || vld_f !== 1'b1) begin
        errors++; $display("FAIL drain_fwft k=%0d got=%h vld=%b want=%h vld=1", k, dout_f, vld_f, k);
      end
      read = 1'b1;
      step();
      checks++;
      if (dout_s !== DW'(k) || vld_s !== 1'b1) begin
        errors++; $display("FAIL drain_std k=%0d got=%h vld=%b want=%h vld=1", k, dout_s, vld_s, k);
      end
    end
    idle();
    step();
    checks++;
    if (empty_f !== 1'b1 || vld_s !== 1'b0 || vld_f !== 1'b0 || dout_s !== 32'd15) begin
      errors++; $display("FAIL drain_end got=e%b vs%b vf%b d%h want=e1 vs0 vf0 d0000000f", empty_f, vld_s, vld_f, dout_s);
    end
  endtask

  task automatic test_single();
    push_n(1, 32'hA5);
    checks++;
    if (empty_f !== 1'b0 || dout_f !== 32'hA5 || vld_f !== 1'b1) begin
      errors++; $display("FAIL single_fwft got=e%b d%h v%b want=e0 d000000a5 v1", empty_f, dout_f, vld_f);
    end
    checks++;
    if (vld_s !== 1'b0 || empty_s !== 1'b0) begin
      errors++; $display("FAIL single_std_prepop got=v%b e%b want=v0 e0", vld_s, empty_s);
    end
    read = 1'b1;
    step();
    idle();
    checks++;
    if (dout_s !== 32'hA5 || vld_s !== 1'b1) begin
      errors++; $display("FAIL single_std_pop got=%h v%b want=000000a5 v1", dout_s, vld_s);
    end
    step();
    checks++;
    if (vld_s !== 1'b0 || dout_s !== 32'hA5 || empty_s !== 1'b1) begin
      errors++; $display("FAIL single_std_hold got=%h v%b e%b want=000000a5 v0 e1", dout_s, vld_s, empty_s);
    end
  endtask

  task automatic test_simultaneous();
    push_n(DEPTH, 32'h10);
    write = 1'b1; read = 1'b1; din = 32'h100;
    step();
    idle();
    checks++;
    if (count_f !== 5'd16 || full_f !== 1'b1 || ovf_f !== 1'b0) begin
      errors++; $display("FAIL full_rw_count got=%0d full=%b ovf=%b want=16 1 0", count_f, full_f, ovf_f);
    end
    checks++;
    if (dout_s !== 32'h10 || dout_f !== 32'h11) begin
      errors++; $display("FAIL full_rw_head got=%h/%h want=00000010/00000011", dout_s, dout_f);
    end
    for (int k = 0; k < DEPTH; k++) begin
      logic [DW-1:0] want;
      want = (k == DEPTH - 1) ? 32'h100 : 32'h11 + DW'(k);
      read = 1'b1;
      step();
      checks++;
      if (dout_s !== want) begin
        errors++; $display("FAIL full_rw_order k=%0d got=%h want=%h", k, dout_s, want);
      end
    end
    // empty: write accepted, read refused
    write = 1'b1; read = 1'b1; din = 32'h55;
    step();
    idle();
    checks++;
    if (unf_f !== 1'b1 || unf_s !== 1'b1 || count_f !== 5'd1 || vld_s !== 1'b0) begin
      errors++; $display("FAIL empty_rw got=u%b%b cnt=%0d vs=%b want=u11 cnt=1 vs=0", unf_f, unf_s, count_f, vld_s);
    end
    read = 1'b1;
    step();
    idle();
    checks++;
    if (unf_f !== 1'b0 || dout_s !== 32'h55 || count_s !== 5'd0) begin
      errors++; $display("FAIL empty_rw_pop got=u%b d%h cnt=%0d want=u0 d00000055 cnt=0", unf_f, dout_s, count_s);
    end
  endtask

  task automatic test_flush();
    push_n(8, 32'h0);
    checks++;
    if (count_f !== 5'd8) begin
      errors++; $display("FAIL flush_pre got=%0d want=8", count_f);
    end
    flush = 1'b1; write = 1'b1; read = 1'b1; din = 32'hEE;
    step();
    idle();
    checks++;
    if (count_f !== 5'd0 || count_s !== 5'd0 || empty_f !== 1'b1 || empty_s !== 1'b1) begin
      errors++; $display("FAIL flush_clear got=%0d/%0d e=%b%b want=0/0 e=11", count_f, count_s, empty_f, empty_s);
    end
    checks++;
    if ({ovf_f, unf_f, ovf_s, unf_s, vld_f, vld_s} !== 6'b0) begin
      errors++; $display("FAIL flush_pulses got=%b want=000000", {ovf_f, unf_f, ovf_s, unf_s, vld_f, vld_s});
    end
    push_n(1, 32'h7);
    checks++;
    if (dout_f !== 32'h7 || count_f !== 5'd1) begin
      errors++; $display("FAIL flush_after_fwft got=%h cnt=%0d want=00000007 cnt=1", dout_f, count_f);
    end
    read = 1'b1;
    step();
    idle();
    checks++;
    if (dout_s !== 32'h7 || vld_s !== 1'b1) begin
      errors++; $display("FAIL flush_after_std got=%h v%b want=00000007 v1", dout_s, vld_s);
    end
  endtask

  task automatic test_random();
    logic          full_m, empty_m, rd_ok, wr_ok;
    logic [DW-1:0] popped;
    exp_q.delete();
    for (int n = 0; n < 200; n++) begin
      if (n == 100) begin
        idle();
        rst = 1'b1;
        #1;
        checks++;
        if (count_f !== 5'd0 || count_s !== 5'd0 || empty_f !== 1'b1 || empty_s !== 1'b1 ||
            vld_f !== 1'b0 || vld_s !== 1'b0 || dout_s !== 32'h0 || full_f !== 1'b0 ||
            ovf_f !== 1'b0 || unf_f !== 1'b0 || ovf_s !== 1'b0 || unf_s !== 1'b0) begin
          errors++; $display("FAIL midrst got=cnt%0d/%0d e%b%b v%b%b d%h want=cnt0/0 e11 v00 d0", count_f, count_s, empty_f, empty_s, vld_f, vld_s, dout_s);
        end
        exp_q.delete();
        step();
        rst = 1'b0;
      end
      write = (n < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      read  = (n < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      din   = $urandom;
      full_m  = (exp_q.size() == DEPTH);
      empty_m = (exp_q.size() == 0);
      rd_ok   = read && !empty_m;
      wr_ok   = write && (!full_m || rd_ok);
      popped  = '0;
      if (!empty_m) begin
        checks++;
        if (dout_f !== exp_q[0] || vld_f !== 1'b1) begin
          errors++; $display("FAIL rand_fwft n=%0d got=%h want=%h", n, dout_f, exp_q[0]);
        end
      end
      if (rd_ok) popped = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(din);
      step();
      checks++;
      if (count_f !== 5'(exp_q.size()) || count_s !== 5'(exp_q.size())) begin
        errors++; $display("FAIL rand_count n=%0d got=%0d/%0d want=%0d", n, count_f, count_s, exp_q.size());
      end
      checks++;
      if (vld_s !== rd_ok || (rd_ok && dout_s !== popped)) begin
        errors++; $display("FAIL rand_std n=%0d got=%h v%b want=%h v%b", n, dout_s, vld_s, popped, rd_ok);
      end
      checks++;
      if (ovf_f !== (write && full_m && !rd_ok) || unf_s !== (read && empty_m)) begin
        errors++; $display("FAIL rand_pulses n=%0d got=o%b u%b want=o%b u%b", n, ovf_f, unf_s, (write && full_m && !rd_ok), (read && empty_m));
      end
    end
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_single();
    test_simultaneous();
    test_flush();
    test_random();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
